reg_write_arbiter: RTL and testbench
====================================

Name: reg_write_arbiter

Overview:
- Shares the single 32-bit result register of the calculator datapath between two write requesters: requester 0 (ALU result path) and requester 1 (operand/keypad load path).
- Also serves one read requester.
- Drives the register's chip-enable, write-enable and data-in strobes.
- The register captures on the falling clock edge. This block drives all strobes from rising-edge flops, so they are stable across that falling edge.

Parameters:
- DATA_W, 32, width of the register and all data ports.
- HOLD_MAX, 4, maximum number of cycles a requester may keep req asserted after done before a forced release.

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst_n  in  1  asynchronous active-low reset
- req0  in  1  write request, requester 0; level, held until done0
- wdata0  in  DATA_W  write data, requester 0; stable while req0=1
- done0  out  1  one-cycle pulse: requester 0 write committed
- req1  in  1  write request, requester 1
- wdata1  in  DATA_W  write data, requester 1
- done1  out  1  one-cycle pulse: requester 1 write committed
- rd_req  in  1  read request; level
- rd_data  out  DATA_W  registered read data
- rd_valid  out  1  one-cycle pulse: rd_data valid
- ram_ce  out  1  register chip enable
- ram_we  out  1  register write enable
- ram_di  out  DATA_W  register write data
- ram_do  in  DATA_W  register read data
- hold_err  out  1  sticky flag: a requester exceeded HOLD_MAX

Behaviour:
- Reset values (async assert, sync release): state=IDLE, last=1 (so requester 0 wins first), all outputs 0, rd_data=0, hold_err=0.
- FSM states: IDLE, WRITE, DONE, RELEASE, READ.
- IDLE:
  - Any write request pending -> select winner, go to WRITE. ram_di is registered from the winner's wdata.
  - Else rd_req=1 -> READ.
  - Writes take priority over reads.
- Round-robin between writers:
  - Only one request pending -> that requester wins.
  - Both pending -> the requester not equal to last wins; last is updated to the winner.
- WRITE: exactly one cycle with ram_ce=1, ram_we=1, ram_di=winner's data. The register commits at that cycle's falling edge. Next state DONE.
- DONE: the winner's done pulse is 1 for this cycle; ram_ce=0, ram_we=0. Next state RELEASE.
- RELEASE: waits for the winner's req to drop, then returns to IDLE.
  - A hold counter counts cycles in this state.
  - Counter reaches HOLD_MAX with req still high -> set hold_err, go to IDLE, and mask that requester's req until it is observed low once.
- READ: one cycle with ram_ce=1, ram_we=0. Both rd_data<=ram_do and rd_valid=1 are registered at the end of this cycle, so rd_valid appears the cycle after READ. Next state IDLE.
- rd_req must be held until rd_valid. A requester that still holds rd_req one cycle after rd_valid gets another read.
- Write-to-done latency: 2 cycles after grant (IDLE -> WRITE -> DONE). Read latency: 2 cycles from IDLE.
- Simultaneous req0, req1 and rd_req: one write is served, then the other write, then the read. The read cannot starve indefinitely only if writers respect the release protocol.
- Requester drops req before done: the write has already been committed in WRITE and done still pulses. A req dropping in IDLE is ignored.
- Reset mid-WRITE: strobes clear immediately (async), no done pulse, and the register content is whatever the last falling edge captured.
- ram_ce and ram_we are never both 1 outside WRITE. done0 and done1 are never 1 together.

Optional Feature:
- Macro: REG_WRITE_ARBITER_FIXED_PRIO_EN.
- Defined: fixed priority, requester 0 always beats requester 1; the last pointer is not implemented.
- Undefined: round-robin as specified above.

Decomposition:
- Shared package: state encoding constants (IDLE, WRITE, DONE, RELEASE, READ, 3-bit), DATA_W default, HOLD_MAX default.
- One sub-module: rr_pick2. It is combinational: takes req0, req1, last and returns a one-hot winner. The fixed-priority macro selects its alternative body.

Test Plan:
- Reset, then req0=1 with wdata0=0x0000_00AA -> ram_we high for 1 cycle with ram_di=0xAA; done0 pulses 2 cycles after req0 is first seen; register reads back 0xAA.
- req0 and req1 raised in the same cycle (0x11, 0x22), each dropped after its done -> requester 0 served first, then requester 1; final register value 0x22; done pulses in order done0, done1.
- Repeat both-pending twice -> grant order 0,1,1,0 under round-robin; with REG_WRITE_ARBITER_FIXED_PRIO_EN defined -> order 0,1,0,1.
- After writing 0x1234_5678, assert rd_req -> ram_ce=1, ram_we=0 for one cycle; rd_valid pulses with rd_data=0x1234_5678.
- req1 held high 6 cycles past done1 (HOLD_MAX=4) -> hold_err=1 and FSM back in IDLE; req1 ignored until it drops; req0 is granted meanwhile.
- Assert rst_n=0 during the WRITE cycle -> ram_we, ram_ce and done drop immediately; after release state is IDLE and requester 0 holds first priority.

Source files
------------

// File: rtl/reg_write_arbiter_pkg.sv
// Shared definitions for the result-register write arbiter.
// Optional build macro: REG_WRITE_ARBITER_FIXED_PRIO_EN (fixed priority, no last pointer).
package reg_write_arbiter_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int HOLD_MAX_DEF = 4;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WRITE   = 3'd1;
  localparam logic [2:0] ST_DONE    = 3'd2;
  localparam logic [2:0] ST_RELEASE = 3'd3;
  localparam logic [2:0] ST_READ    = 3'd4;

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Bus bundle between the two writers, the reader, the result register and the arbiter.
// Handshake: req0/req1/rd_req are levels held by the requester until its
// done0/done1/rd_valid one-cycle pulse; wdata is stable while req is high.
// dbg_state mirrors the arbiter FSM state for observation.
interface reg_write_arbiter_if #(parameter int DATA_W = 32) ();
  import reg_write_arbiter_pkg::*;

  logic              req0;
  logic [DATA_W-1:0] wdata0;
  logic              done0;
  logic              req1;
  logic [DATA_W-1:0] wdata1;
  logic              done1;
  logic              rd_req;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              ram_ce;
  logic              ram_we;
  logic [DATA_W-1:0] ram_di;
  logic [DATA_W-1:0] ram_do;
  logic              hold_err;
  state_t            dbg_state;

  modport slave (
    input  req0, wdata0, req1, wdata1, rd_req, ram_do,
    output done0, done1, rd_data, rd_valid, ram_ce, ram_we, ram_di, hold_err, dbg_state
  );

  modport master (
    output req0, wdata0, req1, wdata1, rd_req, ram_do,
    input  done0, done1, rd_data, rd_valid, ram_ce, ram_we, ram_di, hold_err, dbg_state
  );

endinterface

// File: rtl/reg_write_arbiter_rr_pick2.sv
// Two-way combinational winner select, one-hot grant_o (bit0 = requester 0).
// With REG_WRITE_ARBITER_FIXED_PRIO_EN requester 0 always wins and no last input exists.
module reg_write_arbiter_rr_pick2 (
`ifndef REG_WRITE_ARBITER_FIXED_PRIO_EN
  input  logic       last_i,
`endif
  input  logic       req0_i,
  input  logic       req1_i,
  output logic [1:0] grant_o
);

`ifdef REG_WRITE_ARBITER_FIXED_PRIO_EN
  // Requester 0 beats requester 1 unconditionally
  always_comb begin
    grant_o = 2'b00;
    if (req0_i)      grant_o = 2'b01;
    else if (req1_i) grant_o = 2'b10;
  end
`else
  // On contention the requester that did not win the last contention wins
  always_comb begin
    grant_o = 2'b00;
    if (req0_i && req1_i) grant_o = last_i ? 2'b01 : 2'b10;
    else if (req0_i)      grant_o = 2'b01;
    else if (req1_i)      grant_o = 2'b10;
  end
`endif

endmodule

// File: rtl/reg_write_arbiter.sv
// Arbitrates two writers and one reader onto the falling-edge result register.
// All strobes come from rising-edge flops so they are stable across the capture edge.
// Optional build macro: REG_WRITE_ARBITER_FIXED_PRIO_EN (fixed priority, no last pointer).
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int HOLD_MAX = HOLD_MAX_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  reg_write_arbiter_if.slave  bus
);

  localparam int CNT_W = (HOLD_MAX < 2) ? 1 : $clog2(HOLD_MAX);

  state_t            state_q, state_d;
  logic              win_q, win_d;        // 0 = requester 0 granted, 1 = requester 1
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        mask_q, mask_d;      // writers ignored until their req is seen low
  logic              herr_q, herr_d;
  logic              ce_q, ce_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] di_q, di_d;
  logic              done0_q, done0_d;
  logic              done1_q, done1_d;
  logic              rdv_q, rdv_d;
  logic [DATA_W-1:0] rdd_q, rdd_d;
  logic              eff0, eff1, win_req;
  logic [1:0]        grant;
`ifndef REG_WRITE_ARBITER_FIXED_PRIO_EN
  logic              last_q, last_d;      // winner of the most recent contention
`endif

  assign eff0    = bus.req0 & ~mask_q[0];
  assign eff1    = bus.req1 & ~mask_q[1];
  assign win_req = win_q ? bus.req1 : bus.req0;

  reg_write_arbiter_rr_pick2 u_pick (
`ifndef REG_WRITE_ARBITER_FIXED_PRIO_EN
    .last_i  (last_q),
`endif
    .req0_i  (eff0),
    .req1_i  (eff1),
    .grant_o (grant)
  );

  // Next-state and registered-strobe computation
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    herr_d  = herr_q;
    ce_d    = 1'b0;
    we_d    = 1'b0;
    di_d    = di_q;
    done0_d = 1'b0;
    done1_d = 1'b0;
    rdv_d   = 1'b0;
    rdd_d   = rdd_q;
`ifndef REG_WRITE_ARBITER_FIXED_PRIO_EN
    last_d  = last_q;
`endif
    if (!bus.req0) mask_d[0] = 1'b0;
    if (!bus.req1) mask_d[1] = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|grant) begin
          state_d = ST_WRITE;
          win_d   = grant[1];
          ce_d    = 1'b1;
          we_d    = 1'b1;
          di_d    = grant[1] ? bus.wdata1 : bus.wdata0;
`ifndef REG_WRITE_ARBITER_FIXED_PRIO_EN
          if (eff0 && eff1) last_d = grant[1];
`endif
        end else if (bus.rd_req && !rdv_q) begin
          // rdv_q gate: a reader must still hold rd_req one cycle after rd_valid to re-read
          state_d = ST_READ;
          ce_d    = 1'b1;
        end
      end
      ST_WRITE: begin
        state_d = ST_DONE;
        done0_d = ~win_q;
        done1_d = win_q;
      end
      ST_DONE: begin
        state_d = ST_RELEASE;
        cnt_d   = '0;
      end
      ST_RELEASE: begin
        if (!win_req) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_W'(HOLD_MAX - 1)) begin
          herr_d         = 1'b1;
          mask_d[win_q]  = 1'b1;
          state_d        = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_READ: begin
        rdd_d   = bus.ram_do;
        rdv_d   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers, asynchronously cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      win_q   <= 1'b0;
      cnt_q   <= '0;
      mask_q  <= 2'b00;
      herr_q  <= 1'b0;
      ce_q    <= 1'b0;
      we_q    <= 1'b0;
      di_q    <= '0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      rdv_q   <= 1'b0;
      rdd_q   <= '0;
`ifndef REG_WRITE_ARBITER_FIXED_PRIO_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      herr_q  <= herr_d;
      ce_q    <= ce_d;
      we_q    <= we_d;
      di_q    <= di_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      rdv_q   <= rdv_d;
      rdd_q   <= rdd_d;
`ifndef REG_WRITE_ARBITER_FIXED_PRIO_EN
      last_q  <= last_d;
`endif
    end
  end

  assign bus.done0     = done0_q;
  assign bus.done1     = done1_q;
  assign bus.rd_data   = rdd_q;
  assign bus.rd_valid  = rdv_q;
  assign bus.ram_ce    = ce_q;
  assign bus.ram_we    = we_q;
  assign bus.ram_di    = di_q;
  assign bus.hold_err  = herr_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: scoreboard queues filled at issue time from a
// transaction-level model, drained by a negedge monitor.
module tb_reg_write_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  reg_write_arbiter_if #(.DATA_W(32)) bus ();

  reg_write_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock
  always #5 clk = ~clk;

  // result register: captures on the falling edge
  logic [31:0] reg_mem = 32'h0;
  always @(negedge clk) if (bus.ram_ce && bus.ram_we) reg_mem <= bus.ram_di;
  assign bus.ram_do = reg_mem;

  // scoreboard
  logic [31:0] exp_wr_q[$];
  logic [31:0] exp_done_q[$];
  logic [31:0] exp_rd_q[$];

  // reference model state
  bit          m_last = 1'b1;
  logic [31:0] m_reg = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    total++;
    bad++;
    $display("FAIL %s: got %h expected nothing", name, act);
  endtask

  // monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.ram_ce && bus.ram_we) begin
        if (exp_wr_q.size() == 0) unexpected("write_extra", bus.ram_di);
        else check("write_data", bus.ram_di, exp_wr_q.pop_front());
      end
      if (bus.done0 || bus.done1) begin
        check("done_exclusive", {31'b0, bus.done0 & bus.done1}, 32'd0);
        if (exp_done_q.size() == 0) unexpected("done_extra", {31'b0, bus.done1});
        else check("done_order", {31'b0, bus.done1}, exp_done_q.pop_front());
      end
      if (bus.rd_valid) begin
        if (exp_rd_q.size() == 0) unexpected("read_extra", bus.rd_data);
        else check("read_data", bus.rd_data, exp_rd_q.pop_front());
      end
    end
  end

  // driver: one writer transaction, req dropped `hold` cycles after done
  task automatic do_write(input int id, input logic [31:0] d, input int hold, output int lat);
    bit got;
    got = 1'b0;
    lat = 0;
    if (id == 0) begin bus.wdata0 = d; bus.req0 = 1'b1; end
    else         begin bus.wdata1 = d; bus.req1 = 1'b1; end
    while (!got && lat < 60) begin
      @(negedge clk);
      lat++;
      if ((id == 0) ? bus.done0 : bus.done1) got = 1'b1;
    end
    if (!got) unexpected("write_timeout", id);
    repeat (hold) @(negedge clk);
    if (id == 0) bus.req0 = 1'b0;
    else         bus.req1 = 1'b0;
  endtask

  // driver: one read, dropped as soon as rd_valid is seen
  task automatic do_read();
    int  n;
    int  strobes;
    bit  got;
    n = 0;
    strobes = 0;
    got = 1'b0;
    bus.rd_req = 1'b1;
    while (!got && n < 80) begin
      @(negedge clk);
      n++;
      if (bus.ram_ce && !bus.ram_we) strobes++;
      if (bus.rd_valid) got = 1'b1;
    end
    bus.rd_req = 1'b0;
    if (!got) unexpected("read_timeout", n);
    else check("read_strobe_cycles", strobes, 32'd1);
  endtask

  // one scenario: chosen requesters raise together while the arbiter is idle
  task automatic scenario(input bit w0, input logic [31:0] d0, input bit w1, input logic [31:0] d1,
                          input bit rd, input int h0, input int h1);
    int first;
    int lat0;
    int lat1;
    lat0 = 0;
    lat1 = 0;
    first = -1;
    if (w0 && w1) begin
`ifdef REG_WRITE_ARBITER_FIXED_PRIO_EN
      first = 0;
`else
      first = m_last ? 0 : 1;
      m_last = first[0];
`endif
    end else if (w0) first = 0;
    else if (w1) first = 1;
    if (first == 0) begin
      exp_wr_q.push_back(d0); exp_done_q.push_back(32'd0); m_reg = d0;
      if (w1) begin exp_wr_q.push_back(d1); exp_done_q.push_back(32'd1); m_reg = d1; end
    end else if (first == 1) begin
      exp_wr_q.push_back(d1); exp_done_q.push_back(32'd1); m_reg = d1;
      if (w0) begin exp_wr_q.push_back(d0); exp_done_q.push_back(32'd0); m_reg = d0; end
    end
    if (rd) exp_rd_q.push_back(m_reg);
    fork
      if (w0) do_write(0, d0, h0, lat0);
      if (w1) do_write(1, d1, h1, lat1);
      if (rd) do_read();
    join
    if (first == 0) check("first_done_latency", lat0, 32'd2);
    if (first == 1) check("first_done_latency", lat1, 32'd2);
    repeat (3) @(negedge clk);
  endtask

  // watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // main sequence
  initial begin
    int lat;
    bit got;
    int n;
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.rd_req = 1'b0;
    bus.wdata0 = '0; bus.wdata1 = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // reset state
    check("rst_ram_ce", {31'b0, bus.ram_ce}, 32'd0);
    check("rst_ram_we", {31'b0, bus.ram_we}, 32'd0);
    check("rst_done", {30'b0, bus.done1, bus.done0}, 32'd0);
    check("rst_rd_valid", {31'b0, bus.rd_valid}, 32'd0);
    check("rst_rd_data", bus.rd_data, 32'd0);
    check("rst_hold_err", {31'b0, bus.hold_err}, 32'd0);
    check("rst_state", {29'b0, bus.dbg_state}, 32'd0);

    // directed
    scenario(1, 32'h0000_00AA, 0, 32'h0, 0, 0, 0);
    scenario(0, 32'h0, 0, 32'h0, 1, 0, 0);
    scenario(1, 32'h0000_0011, 1, 32'h0000_0022, 0, 0, 0);
    scenario(0, 32'h0, 0, 32'h0, 1, 0, 0);
    scenario(1, 32'h0000_0033, 1, 32'h0000_0044, 0, 1, 1);
    scenario(1, 32'h0000_0055, 1, 32'h0000_0066, 0, 0, 2);
    scenario(1, 32'h1234_5678, 0, 32'h0, 0, 0, 0);
    scenario(0, 32'h0, 0, 32'h0, 1, 0, 0);
    scenario(1, 32'hDEAD_0001, 1, 32'hDEAD_0002, 1, 0, 0);

    // reset during the WRITE cycle
    bus.wdata0 = 32'h0000_0077;
    bus.req0 = 1'b1;
    @(posedge clk);
    #2;
    check("write_strobe_before_rst", {30'b0, bus.ram_ce, bus.ram_we}, 32'd3);
    rst_n = 1'b0;
    #1;
    check("rst_async_strobes", {30'b0, bus.ram_ce, bus.ram_we}, 32'd0);
    check("rst_async_done", {30'b0, bus.done1, bus.done0}, 32'd0);
    bus.req0 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_last = 1'b1;
    @(negedge clk);
    check("post_rst_state", {29'b0, bus.dbg_state}, 32'd0);
    check("post_rst_reg_kept", reg_mem, m_reg);
    scenario(1, 32'h0000_0101, 1, 32'h0000_0202, 1, 0, 0);
    check("hold_err_clear", {31'b0, bus.hold_err}, 32'd0);

    // writer 1 overstays after done
    exp_wr_q.push_back(32'h0000_0505);
    exp_done_q.push_back(32'd1);
    m_reg = 32'h0000_0505;
    bus.wdata1 = 32'h0000_0505;
    bus.req1 = 1'b1;
    got = 1'b0;
    n = 0;
    while (!got && n < 60) begin
      @(negedge clk);
      n++;
      if (bus.done1) got = 1'b1;
    end
    if (!got) unexpected("hold_write_timeout", n);
    repeat (6) @(negedge clk);
    check("hold_err_set", {31'b0, bus.hold_err}, 32'd1);
    check("hold_back_idle", {29'b0, bus.dbg_state}, 32'd0);
    exp_wr_q.push_back(32'h0000_0606);
    exp_done_q.push_back(32'd0);
    m_reg = 32'h0000_0606;
    do_write(0, 32'h0000_0606, 0, lat);
    check("masked_req0_latency", lat, 32'd2);
    repeat (4) @(negedge clk);
    bus.req1 = 1'b0;
    repeat (3) @(negedge clk);
    scenario(0, 32'h0, 1, 32'h0000_0909, 1, 0, 0);

    // random
    for (int i = 0; i < 40; i++) begin
      scenario($urandom_range(0, 1), $urandom, $urandom_range(0, 1), $urandom,
               $urandom_range(0, 1), $urandom_range(0, 2), $urandom_range(0, 2));
    end

    repeat (4) @(negedge clk);
    check("hold_err_sticky", {31'b0, bus.hold_err}, 32'd1);
    check("final_reg", reg_mem, m_reg);
    check("exp_wr_left", exp_wr_q.size(), 32'd0);
    check("exp_done_left", exp_done_q.size(), 32'd0);
    check("exp_rd_left", exp_rd_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
